// File: rtl/seq_detect_n.sv
// ----------------------------------------------------------------------------
// seq_detect_n
// Serial N-bit pattern detector (Moore). The state is the length of the
// longest prefix of PATTERN that is a suffix of the consumed bit stream
// (KMP automaton). The transition table is built at elaboration from N,
// PATTERN and OVERLAP. A saturating counter counts completed matches.
//
// Parameters
//   N        pattern length in bits (2..8)
//   PATTERN  target sequence, MSB received first
//   OVERLAP  1 = overlapping detection, 0 = restart from empty after a match
//   CNT_W    match counter width
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   en         sample enable; x is consumed only when en=1
//   x          serial input bit
//   clr_cnt    synchronous clear of match_cnt (acts even with en=0)
//   y          detect flag, high while state==N
//   state      matched-prefix length 0..N
//   match_cnt  detections since reset/clear, saturating
// ----------------------------------------------------------------------------
module seq_detect_n #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8,
   localparam int            STATE_W = $clog2(N+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               x,
   input  logic               clr_cnt,
   output logic               y,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam logic [STATE_W-1:0] FULL    = STATE_W'(N);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam int                 TBL_D   = 2**STATE_W;

   // Length of the longest proper border of PATTERN (prefix == suffix, < N).
   function automatic int border_len();
      int b;
      bit ok;
      b = 0;
      for (int l = 1; l < N; l++) begin
         ok = 1'b1;
         for (int j = 0; j < N; j++) begin
            if (j < l) begin
               if (PATTERN[N-1-j] != PATTERN[l-1-j]) begin
                  ok = 1'b0;
               end else begin
                  ok = ok;
               end
            end else begin
               ok = ok;
            end
         end
         if (ok) begin
            b = l;
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

   // Next state from state k_in on input bit xb. State N is first mapped to
   // the restart point (border for overlap, 0 otherwise); a mismatch falls
   // back to the longest prefix that is a suffix of (first k bits, xb).
   function automatic int next_of(input int k_in, input bit xb);
      int  k;
      int  best;
      int  si;
      bit  ok;
      bit  sb;
      if (k_in == N) begin
         k = OVERLAP ? border_len() : 0;
      end else begin
         k = k_in;
      end
      best = 0;
      if (xb == PATTERN[N-1-k]) begin
         best = k + 1;
      end else begin
         for (int l = 1; l <= N; l++) begin
            if (l <= k) begin
               ok = 1'b1;
               for (int j = 0; j < N; j++) begin
                  if (j < l) begin
                     si = k + 1 - l + j;
                     sb = (si < k) ? PATTERN[N-1-si] : xb;
                     if (sb != PATTERN[N-1-j]) begin
                        ok = 1'b0;
                     end else begin
                        ok = ok;
                     end
                  end else begin
                     ok = ok;
                  end
               end
               if (ok) begin
                  best = l;
               end else begin
                  best = best;
               end
            end else begin
               best = best;
            end
         end
      end
      return best;
   endfunction

   logic [STATE_W-1:0] nxt_tbl_s [TBL_D][2];
   logic [STATE_W-1:0] state_r;
   logic [STATE_W-1:0] state_nxt_s;
   logic               inc_s;
   logic [CNT_W-1:0]   cnt_r;

   // Elaboration-time transition table; encodings above N are unreachable.
   for (genvar k = 0; k < TBL_D; k++) begin : g_row
      for (genvar b = 0; b < 2; b++) begin : g_col
         if (k <= N) begin : g_live
            localparam logic [STATE_W-1:0] NXT_V = STATE_W'(next_of(k, (b == 1)));
            assign nxt_tbl_s[k][b] = NXT_V;
         end else begin : g_dead
            assign nxt_tbl_s[k][b] = '0;
         end
      end
   end

   // State register: reset first, advance only on enabled samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= '0;
      end else if (en) begin
         state_r <= state_nxt_s;
      end else begin
         state_r <= state_r;
      end
   end

   // Next-state lookup.
   always_comb begin
      state_nxt_s = nxt_tbl_s[state_r][x];
   end

   // Moore output decode from the state register only.
   always_comb begin
      y = (state_r == FULL);
   end

   // A match completes on an enabled edge whose next state is N.
   always_comb begin
      inc_s = en & (state_nxt_s == FULL);
   end

   // Match counter: clear wins over hold, but a coincident match counts as 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr_cnt) begin
         cnt_r <= inc_s ? CNT_ONE : '0;
      end else if (inc_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign state     = state_r;
   assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_n.sv
// Bench for seq_detect_n: five parameterisations share one input stream;
// each is checked against a history-based reference (longest pattern prefix
// that is a suffix of the consumed bits) and against directed expectations.
module tb_seq_detect_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic x = 1'b0;
   logic clr_cnt = 1'b0;

   always #5 clk = ~clk;

   // inst0: 1011 overlap; inst1: 1011 non-overlap; inst2: 1011 CNT_W=2;
   // inst3: 110 overlap; inst4: 110110 overlap
   localparam int PN[5]   = '{4, 4, 4, 3, 6};
   localparam int PP[5]   = '{11, 11, 11, 6, 54};
   localparam int PO[5]   = '{1, 0, 1, 1, 1};
   localparam int PMAX[5] = '{255, 255, 3, 255, 255};

   logic [2:0] st0, st1, st2, st4;
   logic [1:0] st3;
   logic [7:0] c0, c1, c3, c4;
   logic [1:0] c2;
   logic       y0, y1, y2, y3, y4;

   seq_detect_n #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y0), .state(st0), .match_cnt(c0));
   seq_detect_n #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y1), .state(st1), .match_cnt(c1));
   seq_detect_n #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y2), .state(st2), .match_cnt(c2));
   seq_detect_n #(.N(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(8)) u3 (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y3), .state(st3), .match_cnt(c3));
   seq_detect_n #(.N(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(8)) u4 (
      .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y4), .state(st4), .match_cnt(c4));

   logic [7:0] st_a [5];
   logic [7:0] cnt_a [5];
   logic       y_a [5];
   assign st_a[0] = 8'(st0);  assign st_a[1] = 8'(st1);  assign st_a[2] = 8'(st2);
   assign st_a[3] = 8'(st3);  assign st_a[4] = 8'(st4);
   assign cnt_a[0] = c0;      assign cnt_a[1] = c1;      assign cnt_a[2] = 8'(c2);
   assign cnt_a[3] = c3;      assign cnt_a[4] = c4;
   assign y_a[0] = y0; assign y_a[1] = y1; assign y_a[2] = y2; assign y_a[3] = y3; assign y_a[4] = y4;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   int m_state [5];
   int m_cnt [5];
   int m_len [5];
   int m_bits [5];

   // Drive one cycle, then advance the reference model with the sampled inputs.
   task automatic step(input logic e, input logic xv, input logic c, input logic r);
      int k;
      @(negedge clk);
      en = e; x = xv; clr_cnt = c; rst = r;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         if (r) begin
            m_state[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_bits[i] = 0;
         end else if (e) begin
            m_bits[i] = ((m_bits[i] << 1) | int'(xv)) & 255;
            m_len[i]  = (m_len[i] < 8) ? m_len[i] + 1 : 8;
            k = 0;
            for (int l = 1; l <= PN[i]; l++)
               if (l <= m_len[i] && ((m_bits[i] & ((1 << l) - 1)) == (PP[i] >> (PN[i] - l))))
                  k = l;
            m_state[i] = k;
            if (k == PN[i]) begin
               if (PO[i] == 0) m_len[i] = 0;
               if (c) m_cnt[i] = 1;
               else if (m_cnt[i] < PMAX[i]) m_cnt[i] = m_cnt[i] + 1;
            end else if (c) begin
               m_cnt[i] = 0;
            end
         end else if (c) begin
            m_cnt[i] = 0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (st_a[i] !== 8'd0 || y_a[i] !== 1'b0 || cnt_a[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset inst%0d: state=%0d y=%b cnt=%0d, want 0/0/0", i, st_a[i], y_a[i], cnt_a[i]);
         end
      end
   endtask

   task automatic test_overlap();
      int bits [7] = '{1, 0, 1, 1, 0, 1, 1};
      int e0 [7]   = '{1, 2, 3, 4, 2, 3, 4};
      int e1 [7]   = '{1, 2, 3, 4, 0, 1, 1};
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
         n_chk++;
         if (st_a[0] !== 8'(e0[i]) || y_a[0] !== (e0[i] == 4)) begin
            n_fail++;
            $display("FAIL overlap bit%0d: state=%0d y=%b, want %0d/%b", i, st_a[0], y_a[0], e0[i], (e0[i] == 4));
         end
         n_chk++;
         if (st_a[1] !== 8'(e1[i]) || y_a[1] !== (e1[i] == 4)) begin
            n_fail++;
            $display("FAIL nonoverlap bit%0d: state=%0d y=%b, want %0d/%b", i, st_a[1], y_a[1], e1[i], (e1[i] == 4));
         end
      end
      n_chk++;
      if (cnt_a[0] !== 8'd2 || cnt_a[1] !== 8'd1) begin
         n_fail++;
         $display("FAIL overlap_cnt: got %0d/%0d, want 2/1", cnt_a[0], cnt_a[1]);
      end
   endtask

   task automatic test_gaps();
      int bits [4] = '{1, 0, 1, 1};
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
         for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            n_chk++;
            if (st_a[0] !== 8'(i + 1) || y_a[0] !== (i == 3)) begin
               n_fail++;
               $display("FAIL gap hold bit%0d: state=%0d y=%b, want %0d/%b", i, st_a[0], y_a[0], i + 1, (i == 3));
            end
         end
      end
      n_chk++;
      if (cnt_a[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL gap_cnt: got %0d, want 1", cnt_a[0]);
      end
   endtask

   task automatic test_rst_mid();
      int bits [7] = '{1, 0, 1, 1, 1, 0, 1};
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
      n_chk++;
      if (st_a[0] !== 8'd3 || cnt_a[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL rst_mid pre: state=%0d cnt=%0d, want 3/1", st_a[0], cnt_a[0]);
      end
      // reset while the next bit would complete a match
      step(1'b1, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (st_a[0] !== 8'd0 || y_a[0] !== 1'b0 || cnt_a[0] !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_mid: state=%0d y=%b cnt=%0d, want 0/0/0", st_a[0], y_a[0], cnt_a[0]);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
      n_chk++;
      if (st_a[0] !== 8'd4 || y_a[0] !== 1'b1 || cnt_a[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL rst_mid post: state=%0d y=%b cnt=%0d, want 4/1/1", st_a[0], y_a[0], cnt_a[0]);
      end
   endtask

   task automatic test_sat_clear();
      int bits [4] = '{1, 0, 1, 1};
      int ec [4]   = '{1, 2, 3, 3};
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < 4; i++) step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
         n_chk++;
         if (cnt_a[2] !== 8'(ec[m])) begin
            n_fail++;
            $display("FAIL sat match%0d: cnt=%0d, want %0d", m + 1, cnt_a[2], ec[m]);
         end
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      n_chk++;
      if (cnt_a[2] !== 8'd1 || cnt_a[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL clr_with_match: cnt=%0d/%0d, want 1/1", cnt_a[2], cnt_a[0]);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_chk++;
      if (cnt_a[2] !== 8'd0 || st_a[2] !== 8'd4 || y_a[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_alone: cnt=%0d state=%0d y=%b, want 0/4/1", cnt_a[2], st_a[2], y_a[2]);
      end
   endtask

   task automatic test_alt_pattern();
      int bits [4] = '{1, 1, 1, 0};
      int e3 [4]   = '{1, 2, 2, 3};
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'(bits[i]), 1'b0, 1'b0);
         n_chk++;
         if (st_a[3] !== 8'(e3[i]) || y_a[3] !== (e3[i] == 3)) begin
            n_fail++;
            $display("FAIL alt bit%0d: state=%0d y=%b, want %0d/%b", i, st_a[3], y_a[3], e3[i], (e3[i] == 3));
         end
      end
      n_chk++;
      if (cnt_a[3] !== 8'd1) begin
         n_fail++;
         $display("FAIL alt_cnt: got %0d, want 1", cnt_a[3]);
      end
   endtask

   task automatic test_random();
      logic r, e, c, xv;
      for (int t = 0; t < 600; t++) begin
         r  = ($urandom_range(0, 79) == 0);
         e  = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 19) == 0);
         xv = 1'($urandom_range(0, 1));
         step(e, xv, c, r);
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (st_a[i] !== 8'(m_state[i]) || y_a[i] !== (m_state[i] == PN[i]) || cnt_a[i] !== 8'(m_cnt[i])) begin
               n_fail++;
               $display("FAIL random t%0d inst%0d: state=%0d y=%b cnt=%0d, want %0d/%b/%0d", t, i,
                        st_a[i], y_a[i], cnt_a[i], m_state[i], (m_state[i] == PN[i]), m_cnt[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_gaps();
      test_rst_mid();
      test_sat_clear();
      test_alt_pattern();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
